scoreboard_regfile: RTL
=======================

Name: scoreboard_regfile

Overview:
- Parametrised, clocked register file with an integrated tag-based scoreboard for the in-order pipeline.
- Decode/operand-fetch stage:
  - reads two source registers and their busy bits;
  - issues a destination register, receiving a tag.
- Writeback stage returns data plus tag.
- Busy is cleared only by the most recent issuer of that register, which resolves back-to-back writes to the same destination (WAW).

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 16, number of architectural registers
- ADDR_W, $clog2(NUM_REGS), register index width
- TAG_W, 3, issue tag width; at most 2**TAG_W-1 writes in flight

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_addr1  in  ADDR_W  source register 1 index
- rd_addr2  in  ADDR_W  source register 2 index
- rd_data1  out  DATA_W  value of rd_addr1
- rd_data2  out  DATA_W  value of rd_addr2
- rd_busy1  out  1  rd_addr1 has a pending write
- rd_busy2  out  1  rd_addr2 has a pending write
- iss_valid  in  1  request to mark a destination register busy
- iss_addr  in  ADDR_W  destination register being issued
- iss_ready  out  1  issue accepted this cycle when high
- iss_tag  out  TAG_W  tag given to the issuing instruction
- wb_valid  in  1  writeback strobe
- wb_addr  in  ADDR_W  writeback register index
- wb_data  in  DATA_W  writeback value
- wb_tag  in  TAG_W  tag returned with the writeback

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset: all r[i]=0, busy[i]=0, last_tag[i]=0, next_tag=0, inflight=0.
  - Resulting outputs: rd_data*=0, rd_busy*=0, iss_ready=1, iss_tag=0.
  - Reset overrides iss_valid/wb_valid in the same cycle.
  - Any transaction in flight is discarded.
- Reads: combinational from current state, zero latency.
  - rd_data*=r[rd_addr*]; rd_busy*=busy[rd_addr*].
  - No same-cycle write visibility, unless the optional feature is on.
- Issue handshake:
  - iss_tag=next_tag (combinational).
  - iss_ready=(inflight != 2**TAG_W-1).
  - Fire = iss_valid & iss_ready. On fire:
    - busy[iss_addr]<=1
    - last_tag[iss_addr]<=next_tag
    - next_tag<=next_tag+1, wrapping modulo 2**TAG_W
    - inflight<=inflight+1
  - iss_valid while iss_ready is low: no state change.
- Writeback:
  - Writebacks arrive in issue order (pipeline guarantee).
  - On wb_valid with inflight>0:
    - r[wb_addr]<=wb_data
    - inflight<=inflight-1
    - busy[wb_addr]<=0 only if wb_tag==last_tag[wb_addr]; otherwise busy is unchanged (a newer writer is pending).
  - wb_valid with inflight==0 is a protocol error and is ignored entirely: no data write, counters hold.
- Simultaneous issue and writeback:
  - Same cycle: inflight is unchanged.
  - Same register: data is written; busy ends at 1; last_tag takes the new tag.
  - The issue wins over the clear even when the tags match.
- Wrap: next_tag wraps 7->0 (TAG_W=3). Tags cannot alias while in flight because inflight is capped at 2**TAG_W-1.

Optional Feature:
- Macro: SCOREBOARD_REGFILE_BYPASS_EN.
- With the macro defined:
  - When wb_valid (accepted) and wb_addr==rd_addr*, rd_data* returns wb_data in the same cycle.
  - rd_busy* returns 0 if that writeback clears busy, unless a same-cycle issue targets the same register (then 1).
- Without the macro: reads reflect only registered state; the written value is visible the cycle after the writeback.

Decomposition:
- Package scoreboard_regfile_pkg holds:
  - default DATA_W/NUM_REGS/TAG_W localparams
  - typedefs reg_addr_t, reg_data_t, tag_t
- One sub-module, regfile_scoreboard, owns busy[], last_tag[], next_tag, inflight, iss_ready/iss_tag and the clear-on-tag-match logic.
- The data array and read muxes/bypass stay in the top module.

Test Plan:
1. Reset, then read r0/r15: rd_data*=0, rd_busy*=0, iss_ready=1, iss_tag=0.
2. Basic issue/writeback:
   - Issue R3 (tag 0); next cycle rd_busy(R3)=1.
   - wb R3=16'hBEEF tag 0; next cycle rd_data=16'hBEEF, rd_busy=0.
3. WAW:
   - Issue R3 (tag 0), then issue R3 (tag 1).
   - wb R3=16'h0001 tag 0: busy stays 1, data=16'h0001.
   - wb R3=16'h0002 tag 1: busy=0, data=16'h0002.
4. Capacity:
   - Issue 7 writes with no writeback: iss_ready=0 and an 8th iss_valid is ignored, next_tag=7.
   - One wb: iss_ready=1.
   - A further issue gets tag 7, then the next gets tag 0 (wrap).
5. Same-cycle collision: issue R5 and wb R5 (matching tag) together: busy[R5]=1, inflight unchanged, r[R5]=wb_data.
6. Reset mid-operation and bypass:
   - With 3 in flight, assert reset: busy all 0, inflight=0, iss_tag=0.
   - With BYPASS_EN: wb R2=16'h1234 while rd_addr1=R2 gives rd_data1=16'h1234 in the same cycle.

Source files
------------

// File: rtl/scoreboard_regfile_pkg.sv
// rtl/scoreboard_regfile_pkg.sv - shared defaults and types for the scoreboarded register file
package scoreboard_regfile_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 16;
   localparam int DEF_TAG_W    = 3;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;
   typedef logic [DEF_TAG_W-1:0]  tag_t;

   // One tag value is kept free so a live tag can never be reissued.
   function automatic int maxInflight(input int tagW);
      return (1 << tagW) - 1;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy bits, per-register last issue tag, tag allocator and in-flight count
// Busy read-port bypass is built when SCOREBOARD_REGFILE_BYPASS_EN is defined.
module regfile_scoreboard
   import scoreboard_regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int TAG_W    = DEF_TAG_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issValid,
   input  logic [ADDR_W-1:0] issAddr,
   output logic              issReady,
   output logic [TAG_W-1:0]  issTag,
   input  logic              wbValid,
   input  logic [ADDR_W-1:0] wbAddr,
   input  logic [TAG_W-1:0]  wbTag,
   output logic              wbAccept,
   input  logic [ADDR_W-1:0] rdAddr1,
   input  logic [ADDR_W-1:0] rdAddr2,
   output logic              rdBusy1,
   output logic              rdBusy2
);

   localparam logic [TAG_W-1:0] FULL_COUNT = TAG_W'(maxInflight(TAG_W));

   logic [NUM_REGS-1:0] busy;
   logic [TAG_W-1:0]    lastTag [NUM_REGS];
   logic [TAG_W-1:0]    nextTag;
   logic [TAG_W-1:0]    inflight;
   logic                issFire;
   logic                wbClears;
   logic                sameReg;

   assign issReady = (inflight != FULL_COUNT);
   assign issTag   = nextTag;
   assign issFire  = issValid && issReady;
   assign wbAccept = wbValid && (inflight != '0);
   // Only the newest issuer of a register may release it.
   assign wbClears = wbAccept && (wbTag == lastTag[wbAddr]);
   assign sameReg  = issFire && (issAddr == wbAddr);

   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= '0;
         nextTag  <= '0;
         inflight <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            lastTag[i] <= '0;
         end
      end else begin
         if (issFire) begin
            busy[issAddr]    <= 1'b1;
            lastTag[issAddr] <= nextTag;
            nextTag          <= nextTag + 1'b1;
         end
         if (wbClears && !sameReg) begin
            busy[wbAddr] <= 1'b0;
         end
         if (issFire && !wbAccept) begin
            inflight <= inflight + 1'b1;
         end else if (!issFire && wbAccept) begin
            inflight <= inflight - 1'b1;
         end
      end
   end

`ifdef SCOREBOARD_REGFILE_BYPASS_EN
   logic clrHit1;
   logic clrHit2;

   // A same-cycle issue to the register keeps it busy despite the clear.
   assign clrHit1 = wbClears && (wbAddr == rdAddr1) && !(issFire && (issAddr == rdAddr1));
   assign clrHit2 = wbClears && (wbAddr == rdAddr2) && !(issFire && (issAddr == rdAddr2));
   assign rdBusy1 = busy[rdAddr1] && !clrHit1;
   assign rdBusy2 = busy[rdAddr2] && !clrHit2;
`else
   assign rdBusy1 = busy[rdAddr1];
   assign rdBusy2 = busy[rdAddr2];
`endif

endmodule

// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - register file with tag-based scoreboard for an in-order pipeline
// Same-cycle writeback-to-read forwarding is built when SCOREBOARD_REGFILE_BYPASS_EN is defined.
module scoreboard_regfile
   import scoreboard_regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int TAG_W    = DEF_TAG_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              iss_ready,
   output logic [TAG_W-1:0]  iss_tag,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [TAG_W-1:0]  wb_tag
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              wbAccept;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .TAG_W    (TAG_W)
   ) uScoreboard (
      .clk      (clk),
      .reset    (reset),
      .issValid (iss_valid),
      .issAddr  (iss_addr),
      .issReady (iss_ready),
      .issTag   (iss_tag),
      .wbValid  (wb_valid),
      .wbAddr   (wb_addr),
      .wbTag    (wb_tag),
      .wbAccept (wbAccept),
      .rdAddr1  (rd_addr1),
      .rdAddr2  (rd_addr2),
      .rdBusy1  (rd_busy1),
      .rdBusy2  (rd_busy2)
   );

   // A writeback with nothing in flight is dropped, data included.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wbAccept) begin
         regs[wb_addr] <= wb_data;
      end
   end

`ifdef SCOREBOARD_REGFILE_BYPASS_EN
   assign rd_data1 = (wbAccept && (wb_addr == rd_addr1)) ? wb_data : regs[rd_addr1];
   assign rd_data2 = (wbAccept && (wb_addr == rd_addr2)) ? wb_data : regs[rd_addr2];
`else
   assign rd_data1 = regs[rd_addr1];
   assign rd_data2 = regs[rd_addr2];
`endif

endmodule
